// File: rtl/wt_hybche_partition_ctrl_if.sv
// Bundle between the hybrid-cache partition controller (slave side) and the
// cache core / config agent (master side).
interface wt_hybche_partition_ctrl_if #(
  parameter int NR_WAYS     = 8,
  parameter int INDEX_WIDTH = 8,
  parameter int DOMAIN_W    = 2
);
  logic [DOMAIN_W-1:0]    domain_i;
  logic                   flush_i;
  logic                   wbuffer_empty_i;
  logic                   cfg_we_i;
  logic [DOMAIN_W-1:0]    cfg_domain_i;
  logic [NR_WAYS-1:0]     cfg_way_mask_i;
  logic                   cfg_full_assoc_i;
  // Invalidation handshake: a beat transfers on a cycle where inval_req_o and
  // inval_gnt_i are both high; idx/mask stay stable while req waits for gnt.
  logic                   inval_req_o;
  logic [INDEX_WIDTH-1:0] inval_idx_o;
  logic [NR_WAYS-1:0]     inval_way_mask_o;
  logic                   inval_gnt_i;
  logic [NR_WAYS-1:0]     active_way_mask_o;
  logic                   full_assoc_o;
  logic [DOMAIN_W-1:0]    active_domain_o;
  logic                   stall_o;
  logic                   flush_ack_o;
  logic [2:0]             dbg_state_o;

  modport master (
    output domain_i, flush_i, wbuffer_empty_i, cfg_we_i, cfg_domain_i,
           cfg_way_mask_i, cfg_full_assoc_i, inval_gnt_i,
    input  inval_req_o, inval_idx_o, inval_way_mask_o, active_way_mask_o,
           full_assoc_o, active_domain_o, stall_o, flush_ack_o, dbg_state_o
  );

  modport slave (
    input  domain_i, flush_i, wbuffer_empty_i, cfg_we_i, cfg_domain_i,
           cfg_way_mask_i, cfg_full_assoc_i, inval_gnt_i,
    output inval_req_o, inval_idx_o, inval_way_mask_o, active_way_mask_o,
           full_assoc_o, active_domain_o, stall_o, flush_ack_o, dbg_state_o
  );
endinterface

// File: rtl/wt_hybche_partition_ctrl.sv
// Hybrid-cache way partitioning per isolation domain: debounces domain switches,
// drains the write buffer and walks all sets invalidating the outgoing ways.
module wt_hybche_partition_ctrl #(
  parameter int NR_WAYS        = 8,
  parameter int INDEX_WIDTH    = 8,
  parameter int NR_DOMAINS     = 4,
  parameter int FLUSH_POLICY   = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  wt_hybche_partition_ctrl_if.slave bus
);
  localparam int DOMAIN_W = (NR_DOMAINS > 1) ? $clog2(NR_DOMAINS) : 1;
  localparam int DL_W     = DOMAIN_W + 1;
  localparam int CNT_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [NR_WAYS-1:0]     FULL_MASK = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = '1;
  localparam logic [DL_W-1:0]        DOM_LIMIT = DL_W'(NR_DOMAINS);

  typedef enum logic [2:0] {S_IDLE, S_HOLDOFF, S_DRAIN, S_INVAL, S_DONE} state_e;

  logic [NR_WAYS-1:0]     tbl_mask_q [NR_DOMAINS];
  logic [NR_DOMAINS-1:0]  tbl_fa_q;
  state_e                 state_q, state_d;
  logic [DOMAIN_W-1:0]    active_q, active_d, pending_q, pending_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [NR_WAYS-1:0]     mask_q, mask_d;
  logic                   flush_tag_q, flush_tag_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   flush_ack;
  logic                   cfg_ok;
  logic                   cnt_done;

  assign cfg_ok   = bus.cfg_we_i && (bus.cfg_way_mask_i != '0) &&
                    ({1'b0, bus.cfg_domain_i} < DOM_LIMIT);
  assign cnt_done = (32'(cnt_q) + 32'd1) >= 32'(HOLDOFF_CYCLES);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NR_DOMAINS; d++) tbl_mask_q[d] <= '1;
      tbl_fa_q <= '0;
    end else if (cfg_ok) begin
      for (int d = 0; d < NR_DOMAINS; d++) begin
        if (bus.cfg_domain_i == DOMAIN_W'(d)) begin
          tbl_mask_q[d] <= bus.cfg_way_mask_i;
          tbl_fa_q[d]   <= bus.cfg_full_assoc_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      active_q     <= DOMAIN_W'(NR_DOMAINS - 1);
      pending_q    <= '0;
      pend_vld_q   <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      flush_tag_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_vld_q   <= pend_vld_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      flush_tag_q  <= flush_tag_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_vld_d   = pend_vld_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    flush_tag_d  = flush_tag_q;
    flush_pend_d = flush_pend_q;
    flush_ack    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_i) begin
          state_d     = S_DRAIN;
          mask_d      = FULL_MASK;
          flush_tag_d = 1'b1;
          pend_vld_d  = 1'b0;
        end else if (bus.domain_i != active_q) begin
          state_d   = S_HOLDOFF;
          pending_d = bus.domain_i;
          cnt_d     = CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (bus.flush_i) begin
          state_d     = S_DRAIN;
          mask_d      = FULL_MASK;
          flush_tag_d = 1'b1;
          pend_vld_d  = 1'b1;
        end else if (bus.domain_i == active_q) begin
          state_d = S_IDLE;
        end else if (bus.domain_i != pending_q) begin
          pending_d = bus.domain_i;
          cnt_d     = CNT_W'(1);
        end else if (cnt_done) begin
          if (FLUSH_POLICY == 0) begin
            active_d = pending_q;
            state_d  = S_IDLE;
          end else begin
            // Outgoing domain's ways are the ones that may hold stale lines.
            state_d    = S_DRAIN;
            mask_d     = (FLUSH_POLICY == 1) ? FULL_MASK : tbl_mask_q[active_q];
            pend_vld_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN, S_INVAL: begin
        if (bus.flush_i) begin
          if (mask_q == FULL_MASK) flush_tag_d  = 1'b1;
          else                     flush_pend_d = 1'b1;
        end
        if (state_q == S_DRAIN) begin
          if (bus.wbuffer_empty_i) begin
            state_d = S_INVAL;
            idx_d   = '0;
          end
        end else if (bus.inval_gnt_i) begin
          idx_d = idx_q + INDEX_WIDTH'(1);
          if (idx_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        flush_ack = flush_tag_q && (mask_q == FULL_MASK);
        if (pend_vld_q) begin
          active_d   = pending_q;
          pend_vld_d = 1'b0;
        end
        // A flush seen during a partial-mask walk needs its own full walk.
        if (flush_pend_q) begin
          state_d      = S_DRAIN;
          mask_d       = FULL_MASK;
          flush_tag_d  = 1'b1;
          flush_pend_d = 1'b0;
        end else begin
          state_d     = S_IDLE;
          flush_tag_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.inval_req_o       = (state_q == S_INVAL);
  assign bus.inval_idx_o       = idx_q;
  assign bus.inval_way_mask_o  = mask_q;
  assign bus.active_way_mask_o = tbl_mask_q[active_q];
  assign bus.full_assoc_o      = tbl_fa_q[active_q];
  assign bus.active_domain_o   = active_q;
  assign bus.stall_o           = (state_q != S_IDLE);
  assign bus.flush_ack_o       = flush_ack;
  assign bus.dbg_state_o       = state_q;
endmodule

// File: doc/wt_hybche_partition_ctrl.md
WT_HYBCHE_PARTITION_CTRL -- requirements
Module: wt_hybche_partition_ctrl

Interface
REQ-001 SHALL have parameter NR_WAYS, default 8, cache ways managed.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8, set-index width; the walk covers 2**INDEX_WIDTH sets.
REQ-003 SHALL have parameter NR_DOMAINS, default 4, isolation domains; DOMAIN_W = max(1, $clog2(NR_DOMAINS)).
REQ-004 SHALL have parameter FLUSH_POLICY, default 2; values: 0 RETAIN, 1 FLUSH_ALL, 2 FLUSH_DOMAIN.
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 4, domain-stability debounce (>=1).
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous active-low (already decided).
REQ-007 SHALL have ports: domain_i  in  DOMAIN_W  requested domain; flush_i  in  1  explicit flush request (level); wbuffer_empty_i  in  1  write buffer drained.
REQ-008 SHALL have ports: cfg_we_i  in  1; cfg_domain_i  in  DOMAIN_W; cfg_way_mask_i  in  NR_WAYS; cfg_full_assoc_i  in  1  -- config table write.
REQ-009 SHALL have ports: inval_req_o  out  1; inval_idx_o  out  INDEX_WIDTH; inval_way_mask_o  out  NR_WAYS; inval_gnt_i  in  1  -- invalidation handshake.
REQ-010 SHALL have ports: active_way_mask_o  out  NR_WAYS; full_assoc_o  out  1; active_domain_o  out  DOMAIN_W; stall_o  out  1; flush_ack_o  out  1.

Function
REQ-011 SHALL keep a per-domain table {way_mask, full_assoc}; a cfg_we_i write updates the entry named by cfg_domain_i on the next edge.
REQ-012 SHALL ignore a write with cfg_way_mask_i == 0: the whole entry stays unchanged. A write to cfg_domain_i >= NR_DOMAINS is also ignored.
REQ-013 SHALL drive active_way_mask_o and full_assoc_o combinationally from table[active_domain_q]; a write to the active domain becomes visible the cycle after the write.
REQ-014 SHALL implement FSM states IDLE, HOLDOFF, DRAIN, INVAL, DONE; stall_o = 1 in every state except IDLE.
REQ-015 IDLE: flush_i=1 -> DRAIN with full mask (all ones), flush tagged. Else domain_i != active_domain_q -> HOLDOFF: latch pending=domain_i, counter=1. flush_i takes priority.
REQ-016 HOLDOFF, domain_i == active_domain_q -> IDLE, no commit.
REQ-017 HOLDOFF, domain_i differs from both active and pending -> re-latch pending, counter=1.
REQ-018 HOLDOFF, domain_i == pending -> counter++. On reaching HOLDOFF_CYCLES: RETAIN -> commit pending, IDLE; FLUSH_ALL -> DRAIN, mask all ones; FLUSH_DOMAIN -> DRAIN, mask table[active_domain_q].way_mask.
REQ-019 flush_i in HOLDOFF SHALL go to DRAIN with full mask and flush tagged; pending is committed at DONE.
REQ-020 SHALL snapshot the invalidation mask on DRAIN entry; later config writes do not alter it.
REQ-021 DRAIN -> INVAL on the first cycle wbuffer_empty_i=1; inval_idx resets to 0 on INVAL entry.
REQ-022 INVAL SHALL hold inval_req_o=1, inval_idx_o and inval_way_mask_o stable until inval_gnt_i; on grant, idx++. On grant at idx 2**INDEX_WIDTH-1 (wrap point) -> DONE.
REQ-023 inval_req_o SHALL be 0 outside INVAL.
REQ-024 DONE, one cycle: commit pending if one exists. flush_ack_o=1 iff flush tagged and the walk used the full mask; then -> IDLE.
REQ-025 flush_i arriving in DRAIN/INVAL with a non-full mask SHALL be latched. At DONE, flush_ack_o stays 0 and the FSM re-enters DRAIN with full mask, flush tagged.
REQ-026 flush_i arriving in DRAIN/INVAL of a full-mask walk SHALL be satisfied by that walk.
REQ-027 domain_i changes during DRAIN/INVAL/DONE SHALL be ignored; they are re-evaluated from IDLE.
REQ-028 active_domain_o = active_domain_q; commit updates it on the edge leaving DONE (or leaving HOLDOFF for RETAIN).

Reset
REQ-029 On rst_ni=0 asynchronously: state IDLE; active_domain_q = NR_DOMAINS-1; all table entries way_mask all ones, full_assoc 0; counters, idx, pending, flush tag cleared.
REQ-030 During reset all handshake outputs are 0: inval_req_o=0, stall_o=0, flush_ack_o=0. active_way_mask_o is all ones and full_assoc_o is 0.
REQ-031 Reset mid-walk SHALL abort with no commit and no ack.

Verification (NR_WAYS=4, INDEX_WIDTH=2, NR_DOMAINS=4, HOLDOFF_CYCLES=4, FLUSH_POLICY=2, gnt tied 1, wbuffer_empty_i=1)
REQ-032 Reset release -> active_domain_o=3, active_way_mask_o=4'b1111, stall_o=0.
REQ-033 Write domain3 mask 4'b0011, hold domain_i=0 for 4 cycles -> stall_o=1, inval_way_mask_o=4'b0011 for idx 0..3 over 4 cycles, then active_domain_o=0 after DONE, flush_ack_o=0.
REQ-034 domain_i toggles 0,0,3 within holdoff -> return to IDLE, no inval_req_o, active_domain_o stays 3.
REQ-035 flush_i pulse in IDLE, wbuffer_empty_i=0 for 5 cycles -> inval_req_o stays 0 for those 5 cycles, then 4 walks with mask 4'b1111, then flush_ack_o=1 for exactly one cycle.
REQ-036 flush_i during a FLUSH_DOMAIN walk with mask 4'b0011 -> first DONE gives no ack, a second walk with 4'b1111 follows, then flush_ack_o=1.
REQ-037 Config write with mask 0 -> table unchanged; rst_ni low during INVAL idx=2 -> inval_req_o=0 immediately, active_domain_o=3.
